// File: rtl/wave_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : wave_ctrl_pkg
// Brief   : Shared state encoding and waveform select codes for wave_burst_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
package wave_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SEL_RECIP = 2'd0;
    localparam logic [1:0] SEL_TRI   = 2'd1;
    localparam logic [1:0] SEL_RECT  = 2'd2;
    localparam logic [1:0] SEL_DC    = 2'd3;

    localparam int DC_LEVEL = 128;

endpackage
`default_nettype wire

// File: rtl/phase_accum.sv
`default_nettype none
// ============================================================================
// Module : phase_accum
// Brief  : W-bit phase accumulator with clear, enable and wrap carry.
// Rev    : 1.0  initial release
// ============================================================================
module phase_accum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] step,
    output logic [W-1:0] phase,
    output logic         carry
);

    logic [W:0] w_sum;

    assign w_sum = {1'b0, phase} + {1'b0, step};
    // Carry marks a period boundary; only meaningful while accumulating.
    assign carry = en & w_sum[W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= w_sum[W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wave_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : wave_burst_ctrl
// Brief  : Burst/gap/repeat sequencer driving generator phase and muxing its
//          registered outputs into a single sample stream.
// Rev    : 1.0  initial release
// ============================================================================
module wave_burst_ctrl
    import wave_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_sel,
    input  logic [W-1:0]     cfg_step,
    input  logic [CNT_W-1:0] cfg_cycles,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic             cfg_repeat,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     wave_recip,
    input  logic [W-1:0]     wave_tri,
    input  logic [W-1:0]     wave_rect,
    output logic [W-1:0]     phase,
    output logic             phase_en,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [W-1:0]     sample_out,
    output logic             sample_valid
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [W-1:0]     r_step;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_gap;
    logic             r_repeat;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [1:0]       r_sel_d1;
    logic             r_pe_d1;

    logic             w_carry;
    logic             w_burst_end;
    logic             w_gap_end;
    logic             w_acc_clr;
    logic             w_acc_en;
    logic [W-1:0]     w_mux;

    assign w_burst_end = (r_state == RUN) && w_carry && (r_cycles != '0) &&
                         (r_period_cnt == r_cycles - CNT_W'(1));
    assign w_gap_end   = (r_gap_cnt == r_gap - CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                if (w_burst_end) begin
                    if (r_gap != '0)   w_state_nxt = GAP;
                    else if (r_repeat) w_state_nxt = RUN;
                    else               w_state_nxt = DONE;
                end
            end
            GAP:     if (w_gap_end) w_state_nxt = r_repeat ? RUN : DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (stop && (r_state != IDLE)) w_state_nxt = IDLE;
    end

    // Phase only advances within a burst; every RUN entry (including a
    // back-to-back repeat) restarts from zero.
    assign w_acc_en  = (r_state == RUN);
    assign w_acc_clr = !((r_state == RUN) && (w_state_nxt == RUN) && !w_burst_end);

    phase_accum #(
        .W (W)
    ) u_phase_accum (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_acc_clr),
        .en    (w_acc_en),
        .step  (r_step),
        .phase (phase),
        .carry (w_carry)
    );

    always_comb begin
        w_mux = W'(DC_LEVEL);
        case (r_sel_d1)
            SEL_RECIP: w_mux = wave_recip;
            SEL_TRI:   w_mux = wave_tri;
            SEL_RECT:  w_mux = wave_rect;
            default:   w_mux = W'(DC_LEVEL);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sel        <= SEL_RECIP;
            r_step       <= W'(1);
            r_cycles     <= CNT_W'(1);
            r_gap        <= '0;
            r_repeat     <= 1'b0;
            r_period_cnt <= '0;
            r_gap_cnt    <= '0;
            r_sel_d1     <= SEL_RECIP;
            r_pe_d1      <= 1'b0;
            phase_en     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (cfg_wr && (r_state == IDLE)) begin
                r_sel    <= cfg_sel;
                r_step   <= (cfg_step == '0) ? W'(1) : cfg_step;
                r_cycles <= cfg_cycles;
                r_gap    <= cfg_gap;
                r_repeat <= cfg_repeat;
            end
            cfg_err <= cfg_wr && (r_state != IDLE);

            if (w_acc_clr)    r_period_cnt <= '0;
            else if (w_carry) r_period_cnt <= r_period_cnt + CNT_W'(1);

            if ((r_state == GAP) && (w_state_nxt == GAP)) r_gap_cnt <= r_gap_cnt + CNT_W'(1);
            else                                          r_gap_cnt <= '0;

            phase_en <= (w_state_nxt == RUN);
            busy     <= (w_state_nxt != IDLE);
            done     <= (w_state_nxt == DONE);

            // Two-stage alignment with the generator's own output register.
            r_sel_d1     <= r_sel;
            r_pe_d1      <= phase_en;
            sample_valid <= r_pe_d1;
            sample_out   <= r_pe_d1 ? w_mux : '0;
        end
    end

endmodule
`default_nettype wire
